// File: rtl/csr_pkg.sv
// Shared CSR unit definitions: address map anchors, Zicsr op encoding, counter slots.
// Counter slot numbers equal the low five address bits of the matching CSR.
package csr_pkg;

  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

  typedef enum logic [4:0] {
    CNT_CYCLE   = 5'd0,
    CNT_TIME    = 5'd1,
    CNT_INSTRET = 5'd2,
    CNT_HPM0    = 5'd3
  } cnt_idx_e;

  // Writable mcountinhibit bits: CY, IR and one per implemented hpm counter.
  function automatic logic [31:0] inhibit_mask(int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int j = 0; j < num_hpm; j++) m[int'(CNT_HPM0) + j] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with half-word write port; updates at the clock edge.
// No backpressure: a half write takes priority and suppresses that cycle's increment.
import csr_pkg::*;

module csr_counter64 #(
  parameter logic [63:0] INC = 64'd1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        inc_en,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (res)                     value <= '0;
    else if (wr_lo)              value <= {value[63:32], wdata};
    else if (wr_hi)              value <= {wdata, value[31:0]};
    else if (inc_en && !inhibit) value <= value + INC;
  end

endmodule

// File: rtl/csr_unit.sv
// Zicsr counter/ID register unit; response (ack/rdata/illegal) registered one cycle after req.
// No backpressure: one access accepted every cycle, no stall path.
import csr_pkg::*;

module csr_unit #(
  parameter int HART_ID  = 1,
  parameter int TIME_INC = 40,
  parameter int NUM_HPM  = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               req,
  input  logic [1:0]         op,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               instr_done,
  input  logic [NUM_HPM-1:0] hpm_event,
  output logic               ack,
  output logic [31:0]        rdata,
  output logic               illegal
);

  localparam int          NUM_CNT   = int'(CNT_HPM0) + NUM_HPM;
  localparam logic [5:0]  NUM_CNT_W = 6'(NUM_CNT);
  localparam logic [31:0] INH_MASK  = inhibit_mask(NUM_HPM);

  logic [63:0] cnt_val [32];
  logic [31:0] inhibit;
  logic [4:0]  cidx;
  logic        m_lo, m_hi, u_lo, u_hi, hi;
  logic        is_cnt, is_inh, is_hart, mapped;
  logic        wr_try, legal, do_wr;
  logic [63:0] sel;
  logic [31:0] old_val, new_val;

  assign cidx    = addr[4:0];
  assign m_lo    = addr[11:5] == ADDR_MCYCLE[11:5];
  assign m_hi    = addr[11:5] == ADDR_MCYCLEH[11:5];
  assign u_lo    = addr[11:5] == ADDR_CYCLE[11:5];
  assign u_hi    = addr[11:5] == ADDR_CYCLEH[11:5];
  assign hi      = m_hi | u_hi;
  // Machine bank has no alias for time; only the user shadow exposes it.
  assign is_cnt  = ({1'b0, cidx} < NUM_CNT_W) &
                   (((m_lo | m_hi) & (cidx != CNT_TIME)) | u_lo | u_hi);
  assign is_inh  = addr == ADDR_MCOUNTINHIBIT;
  assign is_hart = addr == ADDR_MHARTID;
  assign mapped  = is_cnt | is_inh | is_hart;

  assign wr_try  = (op == CSR_RW) | (((op == CSR_RS) | (op == CSR_RC)) & (|wdata));
  assign legal   = mapped & ~(wr_try & (addr[11:10] == 2'b11));
  assign do_wr   = req & legal & wr_try;

  assign sel = cnt_val[cidx];

  always_comb begin
    old_val = '0;
    if (is_cnt)       old_val = hi ? sel[63:32] : sel[31:0];
    else if (is_inh)  old_val = inhibit;
    else if (is_hart) old_val = 32'(HART_ID);
    case (op)
      CSR_RW:  new_val = wdata;
      CSR_RS:  new_val = old_val | wdata;
      CSR_RC:  new_val = old_val & ~wdata;
      default: new_val = old_val;
    endcase
  end

  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if (i < NUM_CNT) begin : g_on
      logic inc_en, inh;
      if (i == int'(CNT_CYCLE)) begin : g_cyc
        assign inc_en = 1'b1;
        assign inh    = inhibit[i];
      end else if (i == int'(CNT_TIME)) begin : g_time
        assign inc_en = 1'b1;
        assign inh    = 1'b0;
      end else if (i == int'(CNT_INSTRET)) begin : g_ir
        assign inc_en = instr_done;
        assign inh    = inhibit[i];
      end else begin : g_hpm
        assign inc_en = hpm_event[i - int'(CNT_HPM0)];
        assign inh    = inhibit[i];
      end
      csr_counter64 #(
        .INC (i == int'(CNT_TIME) ? 64'(TIME_INC) : 64'd1)
      ) u_cnt (
        .clk     (clk),
        .res     (res),
        .inc_en  (inc_en),
        .inhibit (inh),
        .wr_lo   (do_wr & is_cnt & ~hi & (cidx == 5'(i))),
        .wr_hi   (do_wr & is_cnt &  hi & (cidx == 5'(i))),
        .wdata   (new_val),
        .value   (cnt_val[i])
      );
    end else begin : g_off
      assign cnt_val[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res)                   inhibit <= '0;
    else if (do_wr && is_inh)  inhibit <= new_val & INH_MASK;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ack     <= 1'b0;
      rdata   <= '0;
      illegal <= 1'b0;
    end else begin
      ack     <= req;
      illegal <= req & ~legal;
      if (req) rdata <= legal ? old_val : '0;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed plus randomized checks of csr_unit against a behavioural CSR model.
module tb_csr_unit;

  localparam int NH   = 4;
  localparam int NC   = 3 + NH;
  localparam int HART = 1;
  localparam int TINC = 40;

  logic          clk = 1'b0;
  logic          res, req, instr_done;
  logic [1:0]    op;
  logic [11:0]   addr;
  logic [31:0]   wdata;
  logic [NH-1:0] hpm_event;
  logic          ack, illegal;
  logic [31:0]   rdata;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] m_cnt [32];
  logic [31:0] m_inh;
  logic        e_ack, e_ill;
  logic [31:0] e_rd = '0;

  csr_unit #(.HART_ID(HART), .TIME_INC(TINC), .NUM_HPM(NH)) dut (
    .clk        (clk),
    .res        (res),
    .req        (req),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .instr_done (instr_done),
    .hpm_event  (hpm_event),
    .ack        (ack),
    .rdata      (rdata),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what the CSR file should do at this edge, from the architectural rules.
  task automatic model_step();
    int          a, kind, idx;
    bit          hi, wr, ill, en;
    logic [31:0] old, nv, mask;
    logic [63:0] c;
    a = int'(addr); kind = 0; idx = 0; hi = 0;
    if (res) begin
      for (int k = 0; k < 32; k++) m_cnt[k] = '0;
      m_inh = '0; e_ack = 0; e_ill = 0; e_rd = '0;
      return;
    end
    for (int k = 0; k < NC; k++) begin
      if (k != 1 && a == 'hB00 + k) begin kind = 1; idx = k; hi = 0; end
      if (k != 1 && a == 'hB80 + k) begin kind = 1; idx = k; hi = 1; end
      if (a == 'hC00 + k)           begin kind = 1; idx = k; hi = 0; end
      if (a == 'hC80 + k)           begin kind = 1; idx = k; hi = 1; end
    end
    if (a == 'h320) kind = 2;
    if (a == 'hF14) kind = 3;
    case (kind)
      1:       old = hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
      2:       old = m_inh;
      3:       old = HART;
      default: old = '0;
    endcase
    wr  = (op == 2'b01) || (op != 2'b00 && wdata != 0);
    ill = (kind == 0) || (wr && a >= 'hC00);
    case (op)
      2'b01:   nv = wdata;
      2'b10:   nv = old | wdata;
      2'b11:   nv = old & ~wdata;
      default: nv = old;
    endcase
    e_ack = req;
    e_ill = req && ill;
    if (req) e_rd = ill ? '0 : old;
    for (int k = 0; k < NC; k++) begin
      if (k == 0)      en = !m_inh[0];
      else if (k == 1) en = 1;
      else if (k == 2) en = instr_done && !m_inh[2];
      else             en = hpm_event[k-3] && !m_inh[k];
      if (req && !ill && wr && kind == 1 && idx == k) begin
        c = m_cnt[k];
        if (hi) c[63:32] = nv; else c[31:0] = nv;
        m_cnt[k] = c;
      end else if (en) begin
        m_cnt[k] = m_cnt[k] + (k == 1 ? 64'(TINC) : 64'd1);
      end
    end
    mask = 32'h5;
    for (int j = 0; j < NH; j++) mask[3+j] = 1'b1;
    if (req && !ill && wr && kind == 2) m_inh = nv & mask;
  endtask

  task automatic cyc(logic r, logic rq, logic [1:0] o, logic [11:0] a, logic [31:0] w,
                     logic id, logic [NH-1:0] ev);
    res = r; req = rq; op = o; addr = a; wdata = w; instr_done = id; hpm_event = ev;
    @(posedge clk);
    model_step();
    #1;
    check($sformatf("ack@%h", a), 32'(ack), 32'(e_ack));
    check($sformatf("illegal@%h", a), 32'(illegal), 32'(e_ill));
    check($sformatf("rdata@%h", a), rdata, e_rd);
  endtask

  task automatic idle(int n, logic id, logic [NH-1:0] ev);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 12'h000, 32'h0, id, ev);
  endtask

  logic [11:0] alist [22] = '{12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB86,
                              12'hB07, 12'hB87, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02,
                              12'hC82, 12'hC05, 12'hC86, 12'hC07, 12'h320, 12'hF14, 12'h321,
                              12'h300};

  initial begin
    logic [31:0] v;
    logic [11:0] ra;
    logic [31:0] rw;

    // cycle counter after 10 idle clocks
    cyc(1, 0, 2'b00, 12'h000, 32'h0, 0, '0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    idle(10, 0, '0);
    cyc(0, 1, 2'b10, 12'hC00, 32'h0, 0, '0);
    check("cycle_after_10", rdata, 32'd10);
    check("cycle_legal", 32'(illegal), 32'h0);

    // time after 10 idle clocks
    cyc(1, 0, 2'b00, 12'h000, 32'h0, 0, '0);
    idle(10, 0, '0);
    cyc(0, 1, 2'b10, 12'hC01, 32'h0, 0, '0);
    check("time_after_10", rdata, 32'd400);

    // 64-bit wrap of the cycle counter
    cyc(0, 1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, '0);
    cyc(0, 1, 2'b01, 12'hB80, 32'hFFFF_FFFF, 0, '0);
    cyc(0, 1, 2'b10, 12'hC00, 32'h0, 0, '0);
    check("cycle_all_ones_lo", rdata, 32'hFFFF_FFFF);
    cyc(0, 1, 2'b10, 12'hC80, 32'h0, 0, '0);
    check("cycle_wrapped_hi", rdata, 32'h0);

    // instret inhibit
    cyc(0, 1, 2'b01, 12'h320, 32'h4, 0, '0);
    cyc(0, 1, 2'b10, 12'hC02, 32'h0, 0, '0);
    v = rdata;
    idle(5, 1, '0);
    cyc(0, 1, 2'b10, 12'hC02, 32'h0, 0, '0);
    check("instret_inhibited", rdata, v);
    cyc(0, 1, 2'b11, 12'h320, 32'h4, 0, '0);
    check("inhibit_old", rdata, 32'h4);
    idle(3, 1, '0);
    cyc(0, 1, 2'b10, 12'hC02, 32'h0, 0, '0);
    check("instret_plus3", rdata, v + 32'd3);

    // illegal write to read-only shadow, legal read, hart id
    cyc(0, 1, 2'b01, 12'hC00, 32'h1, 0, '0);
    check("ro_write_illegal", 32'(illegal), 32'h1);
    check("ro_write_rdata", rdata, 32'h0);
    cyc(0, 1, 2'b10, 12'hC00, 32'h0, 0, '0);
    check("ro_read_legal", 32'(illegal), 32'h0);
    cyc(0, 1, 2'b10, 12'hF14, 32'h0, 0, '0);
    check("hartid", rdata, 32'(HART));

    // unimplemented hpm index, then hpm counter 5
    cyc(1, 0, 2'b00, 12'h000, 32'h0, 0, '0);
    cyc(0, 1, 2'b00, 12'hB07, 32'h0, 0, '0);
    check("hpm_oob_illegal", 32'(illegal), 32'h1);
    idle(7, 0, 4'b0100);
    cyc(0, 1, 2'b10, 12'hC05, 32'h0, 0, '0);
    check("hpm5_count", rdata, 32'd7);

    // reset in the cycle of a request
    cyc(1, 1, 2'b01, 12'hB00, 32'h1234, 0, '0);
    check("reset_req_ack", 32'(ack), 32'h0);
    cyc(0, 1, 2'b10, 12'hC00, 32'h0, 0, '0);
    check("reset_req_cycle", rdata, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : alist[$urandom_range(0, 21)];
      rw = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc($urandom_range(0, 99) < 2, 1'($urandom), 2'($urandom), ra, rw,
          1'($urandom), NH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
